muxn_pipe_reg: RTL and testbench
================================

Name: muxn_pipe_reg

Overview:
- Parametrised N-input operand-select stage with a registered output and valid/ready handshake.
- Generalises the combinational 2:1 select used in the datapath into a stallable, flushable pipeline element.
- Sits between the register-read/forwarding logic and the execute stage.
- A two-entry skid buffer decouples upstream ready from downstream stalls, so in_ready is driven only from registers.

Parameters:
- WIDTH, 32, data width of each input and of the output.
- NUM_IN, 4, number of selectable inputs (>=2).
- SELW, $clog2(NUM_IN), select width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous pipeline flush.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat.
- in_sel  input  SELW  input index for this beat.
- in_data  input  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  1  registered beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  WIDTH  selected data, registered.
- out_sel  output  SELW  select index captured with the beat.
- sel_err  output  1  sticky out-of-range select flag (see Optional Feature).

Behaviour:
- Reset: one clock, synchronous and active-low; rst_n sampled on rising clk.
  - Reset values: out_valid=0, out_data=0, out_sel=0, sel_err=0, skid empty.
  - in_ready=0 while rst_n=0; in_ready=1 on the first cycle after rst_n returns to 1.
  - Reset mid-stream discards all held beats. No partial output is produced.
- Accept: a beat is accepted when in_valid && in_ready at a rising edge.
  - Output selects in_data[in_sel*WIDTH +: WIDTH] sampled at that edge.
  - Data and select are held stable after acceptance regardless of input changes.
- Emit: a beat is consumed when out_valid && out_ready.
- Latency: 1 cycle; out_valid rises the edge after acceptance when the main register is free.
- Storage: main register (drives outputs) plus one skid register.
  - in_ready = rst_n && !skid_valid.
- Per-edge update (priority order):
  1. Flush or reset: clear main_valid and skid_valid. Any beat offered this cycle is dropped. in_ready=1 next cycle (if rst_n=1).
  2. Main empty, or main consumed this cycle: main loads skid if skid_valid (skid clears), otherwise main loads the accepted beat.
     - Skid valid and accept in the same cycle: accepted beat goes to skid, so order is preserved.
  3. Main full, not consumed, accept occurs: beat goes to skid; in_ready falls next cycle.
- Simultaneous consume and accept with skid empty: main reloads with the new beat; out_valid stays 1, giving one beat per cycle.
- Full: main and skid both valid; in_ready=0 until the next consume.
- Empty: out_valid=0; out_data holds its last value (don't-care for checkers).
- Ordering: beats leave in acceptance order. No duplication or loss except on flush/reset.
- Out-of-range select (in_sel >= NUM_IN, only possible when NUM_IN is not a power of two): behaviour is set by the macro below.

Optional Feature:
- Macro MUXN_SEL_CHECK_EN.
- Defined:
  - An accepted beat with in_sel >= NUM_IN is consumed (handshake completes) but not forwarded.
  - sel_err sets to 1 on the following edge and stays set until reset or flush.
  - Also adds an assertion that in_sel never changes while in_valid && !in_ready.
- Undefined:
  - An out-of-range select forwards out_data=0 as a normal beat.
  - sel_err is tied to 0.
  - No assertions.

Test Plan:
- Reset then stream: WIDTH=32, NUM_IN=4, inputs {0xA0,0xB1,0xC2,0xD3}, out_ready=1, in_sel 0,1,2,3 on consecutive cycles -> out_data 0xA0,0xB1,0xC2,0xD3 on cycles 1-4; in_ready stays 1.
- Backpressure: out_ready=0 with 3 beats offered (sel 3,2,1) -> 2 accepted; in_ready=0 from cycle 2. Raise out_ready -> 0xD3,0xC2 in order, then third beat 0xB1 accepted and emitted.
- Flush with full stage: main+skid valid, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered beat absent from output.
- Reset mid-operation: rst_n=0 for 1 cycle with 2 beats held -> out_valid=0, out_data=0, in_ready=0 during reset; after release the first new beat appears 1 cycle after acceptance.
- Out-of-range: NUM_IN=3, in_sel=3 -> macro off: out_data=0, out_valid=1, sel_err=0; macro on: no output beat, sel_err=1 until flush.
- Throughput: out_ready toggling 1,0,1,0 for 16 beats -> all 16 beats delivered in order, no beat lost or duplicated.

Source files
------------

// File: rtl/muxn_pipe_reg.sv
// N-input operand select with a registered, stallable and flushable output (main + skid register).
// Define MUXN_SEL_CHECK_EN to drop out-of-range selects and raise the sticky sel_err flag.
module muxn_pipe_reg #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SELW   = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SELW-1:0]         in_sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_sel,
    output logic                    sel_err
);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [SELW-1:0]  skid_sel;
    logic [WIDTH-1:0] sel_data;
    logic             accept;
    logic             consume;
    logic             fwd;

    // An index with no matching input yields zero, which covers out-of-range selects.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SELW'(k)) begin
                sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready  = rst_n && !skid_valid;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign consume   = main_valid && out_ready;

`ifdef MUXN_SEL_CHECK_EN
    logic sel_ok;

    assign sel_ok = (int'(in_sel) < NUM_IN);
    assign fwd    = accept && sel_ok;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            sel_err <= 1'b0;
        end else if (accept && !sel_ok) begin
            sel_err <= 1'b1;
        end
    end

    sel_stable_a: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready) |=> (!in_valid || $stable(in_sel)));
`else
    assign fwd     = accept;
    assign sel_err = 1'b0;
`endif

    // The skid always holds the younger beat, so it refills main before any new beat does.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            if (!rst_n) begin
                out_data <= '0;
                out_sel  <= '0;
            end
        end else if (!main_valid || consume) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                out_data   <= skid_data;
                out_sel    <= skid_sel;
                skid_valid <= fwd;
                if (fwd) begin
                    skid_data <= sel_data;
                    skid_sel  <= in_sel;
                end
            end else begin
                main_valid <= fwd;
                if (fwd) begin
                    out_data <= sel_data;
                    out_sel  <= in_sel;
                end
            end
        end else if (fwd) begin
            skid_valid <= 1'b1;
            skid_data  <= sel_data;
            skid_sel   <= in_sel;
        end
    end

endmodule

// File: tb/tb_muxn_pipe_reg.sv
// Bench for muxn_pipe_reg: directed table, reset/flush/out-of-range sequences, and a queue-model
// checked throughput and random run.
module tb_muxn_pipe_reg;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_sel;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         sel_err;

    logic         in_valid2;
    logic         in_ready2;
    logic [1:0]   in_sel2;
    logic [23:0]  in_data2;
    logic         out_valid2;
    logic         out_ready2;
    logic [7:0]   out_data2;
    logic [1:0]   out_sel2;
    logic         sel_err2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muxn_pipe_reg #(.WIDTH(32), .NUM_IN(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sel(out_sel), .sel_err(sel_err)
    );

    muxn_pipe_reg #(.WIDTH(8), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_sel(in_sel2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .out_sel(out_sel2), .sel_err(sel_err2)
    );

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  es;
        logic        er;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  s;
    } beat_t;

    vec_t  vecs[17];
    beat_t q[$];
    logic  stalled = 1'b0;
    logic  last_acc = 1'b0;
    int    dut_delivered = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t t, input int idx);
        in_valid  = t.v;
        in_sel    = t.sel;
        out_ready = t.ordy;
        flush     = t.fl;
        tick();
        check($sformatf("vec%0d out_valid", idx), 64'(out_valid), 64'(t.ev));
        check($sformatf("vec%0d in_ready", idx), 64'(in_ready), 64'(t.er));
        if (t.ev) begin
            check($sformatf("vec%0d out_data", idx), 64'(out_data), 64'(t.ed));
            check($sformatf("vec%0d out_sel", idx), 64'(out_sel), 64'(t.es));
        end
    endtask

    // Compare the DUT against the queue model: occupancy decides valid/ready, head decides data.
    task automatic checkOutput();
        logic has_beat;
        has_beat = (q.size() > 0);
        check("model in_ready", 64'(in_ready), 64'(rst_n && (q.size() < 2)));
        check("model out_valid", 64'(out_valid), 64'(has_beat));
        if (has_beat) begin
            check("model out_data", 64'(out_data), 64'(q[0].d));
            check("model out_sel", 64'(out_sel), 64'(q[0].s));
        end
        check("model sel_err", 64'(sel_err), 64'(0));
    endtask

    task automatic stepModel();
        logic  acc;
        logic  cons;
        beat_t b;
        acc     = in_valid && rst_n && (q.size() < 2);
        cons    = (q.size() > 0) && out_ready;
        stalled = in_valid && rst_n && (q.size() >= 2);
        if (out_valid && out_ready) dut_delivered++;
        b.d = 32'(in_data >> (in_sel * 32));
        b.s = in_sel;
        @(posedge clk);
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(b);
        end
        last_acc = acc && !flush;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic newBeat();
        in_sel  = 2'($urandom % 4);
        in_data = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        int beats;

        vecs[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 32'hA0, 2'd0, 1'b1};
        vecs[1]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'hB1, 2'd1, 1'b1};
        vecs[2]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 32'hC2, 2'd2, 1'b1};
        vecs[3]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 32'hD3, 2'd3, 1'b1};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1};
        vecs[5]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 32'hD3, 2'd3, 1'b1};
        vecs[6]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'hD3, 2'd3, 1'b0};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'hD3, 2'd3, 1'b0};
        vecs[8]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'hC2, 2'd2, 1'b1};
        vecs[9]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'hB1, 2'd1, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1};
        vecs[11] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 32'hA0, 2'd0, 1'b1};
        vecs[12] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'hA0, 2'd0, 1'b0};
        vecs[13] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0,  2'd0, 1'b1};
        vecs[14] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1};
        vecs[15] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 32'hD3, 2'd3, 1'b1};
        vecs[16] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1};

        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_sel = 2'd0;
        in_data = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
        out_ready = 1'b0;
        in_valid2 = 1'b0;
        in_sel2 = 2'd0;
        in_data2 = {8'h33, 8'h22, 8'h11};
        out_ready2 = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst out_valid", 64'(out_valid), 64'(0));
        check("rst out_data", 64'(out_data), 64'(0));
        check("rst out_sel", 64'(out_sel), 64'(0));
        check("rst sel_err", 64'(sel_err), 64'(0));
        check("rst in_ready", 64'(in_ready), 64'(0));
        check("rst sel_err n3", 64'(sel_err2), 64'(0));
        rst_n = 1'b1;
        #1;
        check("rst release in_ready", 64'(in_ready), 64'(1));

        for (int i = 0; i < 17; i++) applyStimulus(vecs[i], i);

        // Reset while main and skid both hold beats.
        in_valid = 1'b1; in_sel = 2'd0; out_ready = 1'b0;
        tick();
        in_sel = 2'd1;
        tick();
        check("midrst full in_ready", 64'(in_ready), 64'(0));
        rst_n = 1'b0; in_sel = 2'd2;
        tick();
        check("midrst out_valid", 64'(out_valid), 64'(0));
        check("midrst out_data", 64'(out_data), 64'(0));
        check("midrst in_ready", 64'(in_ready), 64'(0));
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        check("midrst release in_ready", 64'(in_ready), 64'(1));
        tick();
        check("midrst idle out_valid", 64'(out_valid), 64'(0));
        in_valid = 1'b1; in_sel = 2'd2; out_ready = 1'b1;
        tick();
        check("midrst first out_valid", 64'(out_valid), 64'(1));
        check("midrst first out_data", 64'(out_data), 64'(32'hC2));
        in_valid = 1'b0;
        tick();
        check("midrst drained out_valid", 64'(out_valid), 64'(0));

        // Out-of-range select on the three-input instance.
        in_valid2 = 1'b1; in_sel2 = 2'd3; out_ready2 = 1'b1;
        tick();
`ifdef MUXN_SEL_CHECK_EN
        check("oor out_valid", 64'(out_valid2), 64'(0));
        check("oor sel_err", 64'(sel_err2), 64'(1));
`else
        check("oor out_valid", 64'(out_valid2), 64'(1));
        check("oor out_data", 64'(out_data2), 64'(0));
        check("oor out_sel", 64'(out_sel2), 64'(3));
        check("oor sel_err", 64'(sel_err2), 64'(0));
`endif
        check("oor in_ready", 64'(in_ready2), 64'(1));
        in_sel2 = 2'd1;
        tick();
        check("oor next out_valid", 64'(out_valid2), 64'(1));
        check("oor next out_data", 64'(out_data2), 64'(8'h22));
`ifdef MUXN_SEL_CHECK_EN
        check("oor sticky sel_err", 64'(sel_err2), 64'(1));
`else
        check("oor sticky sel_err", 64'(sel_err2), 64'(0));
`endif
        in_valid2 = 1'b0; flush = 1'b1;
        tick();
        check("oor flush out_valid", 64'(out_valid2), 64'(0));
        check("oor flush sel_err", 64'(sel_err2), 64'(0));
        flush = 1'b0;
        out_ready2 = 1'b0;
        in_sel2 = 2'd0;

        // Sixteen beats under alternating out_ready.
        beats = 0;
        dut_delivered = 0;
        newBeat();
        in_valid = 1'b1;
        for (int c = 0; c < 200 && beats < 16; c++) begin
            out_ready = (c % 2 == 0);
            stepModel();
            if (last_acc) begin
                beats++;
                newBeat();
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) stepModel();
        check("tp beats accepted", 64'(beats), 64'(16));
        check("tp beats delivered", 64'(dut_delivered), 64'(16));

        // Random traffic with occasional flush and reset; the producer holds a stalled beat.
        stalled = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!stalled) begin
                in_valid = ($urandom % 4 != 0);
                newBeat();
            end
            out_ready = ($urandom % 3 != 0);
            flush = ($urandom % 25 == 0);
            rst_n = !($urandom % 50 == 0);
            stepModel();
        end
        flush = 1'b0;
        rst_n = 1'b1;
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
